// File: rtl/wb_arbiter_2to1_pkg.sv
`default_nettype none
// ============================================================================
// wb_arbiter_2to1_pkg : shared FSM encodings, grant ids and width helper.
// Rev 1.0
// ============================================================================
package wb_arbiter_2to1_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_GNT0 = 2'd1;
  localparam logic [1:0] ARB_GNT1 = 2'd2;

  localparam logic GNT_M0 = 1'b0;
  localparam logic GNT_M1 = 1'b1;

  // Bits needed to count from 0 to value-1.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_2to1_if.sv
`default_nettype none
// ============================================================================
// wb_arbiter_2to1_if : one Wishbone B4 classic bus (master / slave views).
// Rev 1.0
// ============================================================================
interface wb_arbiter_2to1_if #(
  parameter int ADR_W = 30,
  parameter int DAT_W = 32,
  parameter int SEL_W = 4
);
  logic             cyc;
  logic             stb;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_w;
  logic [SEL_W-1:0] sel;
  logic [DAT_W-1:0] dat_r;
  logic             ack;
  logic             err;

  modport master (output cyc, stb, we, adr, dat_w, sel, input  dat_r, ack, err);
  modport slave  (input  cyc, stb, we, adr, dat_w, sel, output dat_r, ack, err);
endinterface
`default_nettype wire

// File: rtl/wb_arbiter_2to1_timeout.sv
`default_nettype none
// ============================================================================
// wb_arb_timeout : watchdog counter flagging a slave that never terminates.
// Rev 1.0
// ============================================================================
module wb_arb_timeout
  import wb_arbiter_2to1_pkg::*;
#(
  parameter int TMO_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_hit
);
  localparam int CNT_W = clog2(TMO_CYC + 1);

  logic [CNT_W-1:0] r_cnt;

  // A hit self-clears so the error pulse lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst || i_clr || o_hit) r_cnt <= '0;
    else if (i_inc)            r_cnt <= r_cnt + 1'b1;
  end

  assign o_hit = (r_cnt == CNT_W'(TMO_CYC));
endmodule
`default_nettype wire

// File: rtl/wb_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// wb_arbiter_2to1 : round-robin 2:1 Wishbone B4 classic arbiter; a grant is held
// for the whole CYC burst. Optional watchdog enabled by WB_ARB_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
module wb_arbiter_2to1
  import wb_arbiter_2to1_pkg::*;
#(
  parameter int ADR_W   = 30,
  parameter int DAT_W   = 32,
  parameter int SEL_W   = 4,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  wb_arbiter_2to1_if.slave  m0,
  wb_arbiter_2to1_if.slave  m1,
  wb_arbiter_2to1_if.master s
);
  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic             r_last_gnt;
  logic             w_tmo_hit;
  logic             w_cyc, w_stb, w_we;
  logic [ADR_W-1:0] w_adr;
  logic [DAT_W-1:0] w_dat;
  logic [SEL_W-1:0] w_sel;
  logic             w_m0_ack, w_m0_err, w_m1_ack, w_m1_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB_IDLE;
      r_last_gnt <= GNT_M1;
    end else begin
      r_state <= w_next_state;
      if (r_state == ARB_GNT0 && !m0.cyc)      r_last_gnt <= GNT_M0;
      else if (r_state == ARB_GNT1 && !m1.cyc) r_last_gnt <= GNT_M1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (m0.cyc && m1.cyc) w_next_state = (r_last_gnt == GNT_M0) ? ARB_GNT1 : ARB_GNT0;
        else if (m0.cyc)      w_next_state = ARB_GNT0;
        else if (m1.cyc)      w_next_state = ARB_GNT1;
      end
      ARB_GNT0: if (!m0.cyc) w_next_state = ARB_IDLE;
      ARB_GNT1: if (!m1.cyc) w_next_state = ARB_IDLE;
      default:  w_next_state = ARB_IDLE;
    endcase
  end

  // Acks are qualified by the owner's CYC so an abandoned transfer never completes.
  always_comb begin
    w_cyc    = 1'b0;
    w_stb    = 1'b0;
    w_we     = 1'b0;
    w_adr    = '0;
    w_dat    = '0;
    w_sel    = '0;
    w_m0_ack = 1'b0;
    w_m0_err = 1'b0;
    w_m1_ack = 1'b0;
    w_m1_err = 1'b0;
    if (!rst) begin
      case (r_state)
        ARB_GNT0: begin
          w_cyc    = m0.cyc;
          w_stb    = m0.stb && !w_tmo_hit;
          w_we     = m0.we;
          w_adr    = m0.adr;
          w_dat    = m0.dat_w;
          w_sel    = m0.sel;
          w_m0_ack = s.ack && m0.cyc;
          w_m0_err = (s.err && m0.cyc) || w_tmo_hit;
        end
        ARB_GNT1: begin
          w_cyc    = m1.cyc;
          w_stb    = m1.stb && !w_tmo_hit;
          w_we     = m1.we;
          w_adr    = m1.adr;
          w_dat    = m1.dat_w;
          w_sel    = m1.sel;
          w_m1_ack = s.ack && m1.cyc;
          w_m1_err = (s.err && m1.cyc) || w_tmo_hit;
        end
        default: ;
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic w_tmo_inc;
  logic w_tmo_clr;

  assign w_tmo_inc = ((r_state == ARB_GNT0) && m0.stb) || ((r_state == ARB_GNT1) && m1.stb);
  assign w_tmo_clr = (r_state == ARB_IDLE) || s.ack || s.err;

  wb_arb_timeout #(.TMO_CYC(TMO_CYC)) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_tmo_clr),
    .i_inc (w_tmo_inc),
    .o_hit (w_tmo_hit)
  );
`else
  // No watchdog: err is a pure pass-through and the hit term is constant low.
  assign w_tmo_hit = (TMO_CYC < 0);
`endif

  assign s.cyc    = w_cyc;
  assign s.stb    = w_stb;
  assign s.we     = w_we;
  assign s.adr    = w_adr;
  assign s.dat_w  = w_dat;
  assign s.sel    = w_sel;
  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;
  assign m0.ack   = w_m0_ack;
  assign m0.err   = w_m0_err;
  assign m1.ack   = w_m1_ack;
  assign m1.err   = w_m1_err;
endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// tb_wb_arbiter_2to1 : directed self-checking bench for wb_arbiter_2to1.
// Rev 1.0
// ============================================================================
module tb_wb_arbiter_2to1;
  localparam int ADR_W = 30;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter_2to1_if #(.ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W)) m0_bus ();
  wb_arbiter_2to1_if #(.ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W)) m1_bus ();
  wb_arbiter_2to1_if #(.ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W)) s_bus ();

  wb_arbiter_2to1 #(.ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W), .TMO_CYC(8)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_bus),
    .m1  (m1_bus),
    .s   (s_bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    tick();
    m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
    m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
    s_bus.ack  = 1'b0; s_bus.err  = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.adr = 30'h111;
    m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; m1_bus.adr = 30'h222;
    s_bus.ack = 1'b1; s_bus.err = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); #3;
      total++;
      if ({s_bus.cyc, s_bus.stb, m0_bus.ack, m1_bus.ack, m0_bus.err, m1_bus.err} !== 6'b0) begin
        bad++;
        $display("FAIL reset_quiet[%0d]: got cyc/stb/ack0/ack1/err0/err1=%b want 000000", i,
                 {s_bus.cyc, s_bus.stb, m0_bus.ack, m1_bus.ack, m0_bus.err, m1_bus.err});
      end
    end
    s_bus.ack = 1'b0; s_bus.err = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if (s_bus.cyc !== 1'b0) begin bad++; $display("FAIL reset_release_idle: got s_cyc=%b want 0", s_bus.cyc); end
    tick(); #3;
    total++;
    if ({s_bus.cyc, s_bus.adr} !== {1'b1, 30'h111}) begin
      bad++; $display("FAIL reset_first_grant_m0: got cyc=%b adr=%h want cyc=1 adr=111", s_bus.cyc, s_bus.adr);
    end
    idle_bus();
  endtask

  task automatic test_single();
    tick();
    m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; m1_bus.we = 1'b0; m1_bus.adr = 30'h10;
    #3;
    total++;
    if (s_bus.cyc !== 1'b0) begin bad++; $display("FAIL single_latency: got s_cyc=%b want 0", s_bus.cyc); end
    tick(); #3;
    total++;
    if ({s_bus.cyc, s_bus.stb, s_bus.we, s_bus.adr} !== {3'b110, 30'h10}) begin
      bad++; $display("FAIL single_request: got cyc/stb/we=%b%b%b adr=%h want 110 adr=10",
                      s_bus.cyc, s_bus.stb, s_bus.we, s_bus.adr);
    end
    tick();
    s_bus.ack = 1'b1; s_bus.dat_r = 32'hDEADBEEF;
    #3;
    total++;
    if ({m1_bus.ack, m0_bus.ack, m1_bus.dat_r} !== {2'b10, 32'hDEADBEEF}) begin
      bad++; $display("FAIL single_read: got ack1=%b ack0=%b dat1=%h want 1 0 deadbeef",
                      m1_bus.ack, m0_bus.ack, m1_bus.dat_r);
    end
    tick();
    m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0; s_bus.ack = 1'b0;
    #3;
    total++;
    if (m1_bus.ack !== 1'b0) begin bad++; $display("FAIL single_release: got ack1=%b want 0", m1_bus.ack); end
    idle_bus();
  endtask

  task automatic test_contention();
    logic [ADR_W-1:0] exp_adr;
    logic [1:0]       exp_ack;
    tick();
    m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.adr = 30'h100;
    m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; m1_bus.adr = 30'h200;
    #3;
    total++;
    if (s_bus.cyc !== 1'b0) begin bad++; $display("FAIL contend_start_idle: got s_cyc=%b want 0", s_bus.cyc); end
    for (int k = 0; k < 6; k++) begin
      exp_adr = (k % 2 == 0) ? 30'h100 : 30'h200;
      exp_ack = (k % 2 == 0) ? 2'b10 : 2'b01;
      tick();
      s_bus.ack = 1'b1;
      #3;
      total++;
      if ({s_bus.cyc, s_bus.adr} !== {1'b1, exp_adr}) begin
        bad++; $display("FAIL contend_grant[%0d]: got cyc=%b adr=%h want cyc=1 adr=%h", k, s_bus.cyc, s_bus.adr, exp_adr);
      end
      total++;
      if ({m0_bus.ack, m1_bus.ack} !== exp_ack) begin
        bad++; $display("FAIL contend_ack[%0d]: got ack0/ack1=%b want %b", k, {m0_bus.ack, m1_bus.ack}, exp_ack);
      end
      tick();
      s_bus.ack = 1'b0;
      if (k % 2 == 0) begin m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; end
      else            begin m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0; end
      if (k == 5) begin m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; end
      #3;
      total++;
      if (s_bus.cyc !== 1'b0) begin bad++; $display("FAIL contend_drop[%0d]: got s_cyc=%b want 0", k, s_bus.cyc); end
      if (k < 5) begin
        tick();
        if (k % 2 == 0) begin m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; end
        else            begin m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; end
        #3;
        total++;
        if (s_bus.cyc !== 1'b0) begin bad++; $display("FAIL contend_dead_cycle[%0d]: got s_cyc=%b want 0", k, s_bus.cyc); end
      end
    end
    idle_bus();
  endtask

  task automatic test_burst_hold();
    tick();
    m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.adr = 30'h300;
    m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; m1_bus.adr = 30'h400;
    #3;
    for (int b = 0; b < 4; b++) begin
      tick();
      m0_bus.adr = 30'h300 + 30'(b);
      s_bus.ack = 1'b1; s_bus.dat_r = 32'hA000_0000 + 32'(b);
      #3;
      total++;
      if ({s_bus.adr, m0_bus.ack, m1_bus.ack, m0_bus.dat_r} !== {30'h300 + 30'(b), 2'b10, 32'hA000_0000 + 32'(b)}) begin
        bad++; $display("FAIL burst_beat[%0d]: got adr=%h ack0=%b ack1=%b dat0=%h want adr=%h 1 0 dat=%h", b,
                        s_bus.adr, m0_bus.ack, m1_bus.ack, m0_bus.dat_r, 30'h300 + 30'(b), 32'hA000_0000 + 32'(b));
      end
    end
    tick();
    m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; s_bus.ack = 1'b0;
    #3;
    total++;
    if ({s_bus.cyc, m1_bus.ack} !== 2'b00) begin
      bad++; $display("FAIL burst_release: got s_cyc=%b ack1=%b want 0 0", s_bus.cyc, m1_bus.ack);
    end
    tick(); #3;
    total++;
    if (s_bus.cyc !== 1'b0) begin bad++; $display("FAIL burst_dead_cycle: got s_cyc=%b want 0", s_bus.cyc); end
    tick(); #3;
    total++;
    if ({s_bus.cyc, s_bus.adr} !== {1'b1, 30'h400}) begin
      bad++; $display("FAIL burst_m1_grant: got cyc=%b adr=%h want cyc=1 adr=400", s_bus.cyc, s_bus.adr);
    end
    idle_bus();
  endtask

  task automatic test_abort();
    tick();
    m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.adr = 30'h500;
    #3;
    tick(); #3;
    total++;
    if ({s_bus.cyc, s_bus.adr} !== {1'b1, 30'h500}) begin
      bad++; $display("FAIL abort_grant: got cyc=%b adr=%h want cyc=1 adr=500", s_bus.cyc, s_bus.adr);
    end
    tick();
    m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
    #3;
    total++;
    if ({s_bus.cyc, m0_bus.ack} !== 2'b00) begin
      bad++; $display("FAIL abort_drop: got s_cyc=%b ack0=%b want 0 0", s_bus.cyc, m0_bus.ack);
    end
    tick();
    s_bus.ack = 1'b1;
    m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; m1_bus.adr = 30'h600;
    #3;
    total++;
    if ({m0_bus.ack, m1_bus.ack, s_bus.cyc} !== 3'b000) begin
      bad++; $display("FAIL abort_late_ack: got ack0/ack1/s_cyc=%b want 000", {m0_bus.ack, m1_bus.ack, s_bus.cyc});
    end
    tick();
    s_bus.ack = 1'b1; s_bus.err = 1'b1;
    #3;
    total++;
    if ({s_bus.cyc, s_bus.adr} !== {1'b1, 30'h600}) begin
      bad++; $display("FAIL abort_idle_then_m1: got cyc=%b adr=%h want cyc=1 adr=600", s_bus.cyc, s_bus.adr);
    end
    total++;
    if ({m1_bus.ack, m1_bus.err, m0_bus.ack, m0_bus.err} !== 4'b1100) begin
      bad++; $display("FAIL ack_err_both: got ack1/err1/ack0/err0=%b want 1100",
                      {m1_bus.ack, m1_bus.err, m0_bus.ack, m0_bus.err});
    end
    idle_bus();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    tick();
    m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.adr = 30'h700;
    #3;
    total++;
    if (s_bus.stb !== 1'b0) begin bad++; $display("FAIL tmo_pre_grant: got s_stb=%b want 0", s_bus.stb); end
    tick(); #3;
    total++;
    if ({s_bus.stb, m0_bus.err} !== 2'b10) begin
      bad++; $display("FAIL tmo_first_stb: got stb/err0=%b want 10", {s_bus.stb, m0_bus.err});
    end
    for (int c = 1; c < 8; c++) begin
      tick(); #3;
      total++;
      if ({s_bus.stb, m0_bus.err} !== 2'b10) begin
        bad++; $display("FAIL tmo_wait[%0d]: got stb/err0=%b want 10", c, {s_bus.stb, m0_bus.err});
      end
    end
    tick(); #3;
    total++;
    if ({s_bus.stb, m0_bus.err} !== 2'b01) begin
      bad++; $display("FAIL tmo_fire: got stb/err0=%b want 01", {s_bus.stb, m0_bus.err});
    end
    tick(); #3;
    total++;
    if ({s_bus.stb, m0_bus.err} !== 2'b10) begin
      bad++; $display("FAIL tmo_after: got stb/err0=%b want 10", {s_bus.stb, m0_bus.err});
    end
    idle_bus();
  endtask
`endif

  initial begin
    m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; m0_bus.we = 1'b0; m0_bus.adr = '0;
    m0_bus.dat_w = 32'h0000_00A0; m0_bus.sel = 4'hF;
    m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0; m1_bus.we = 1'b0; m1_bus.adr = '0;
    m1_bus.dat_w = 32'h0000_00B1; m1_bus.sel = 4'hF;
    s_bus.ack = 1'b0; s_bus.err = 1'b0; s_bus.dat_r = '0;

    test_reset();
    test_single();
    test_contention();
    test_burst_hold();
    test_abort();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
